// File: rtl/rfile_pkg.sv
// Shared definitions for the weighted-centroid RSSI localisation block:
// FSM state codes, default parameters and derived accumulator widths.
package rfile_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_ACC   = 3'd1;
   localparam state_t ST_DRAIN = 3'd2;
   localparam state_t ST_DIV   = 3'd3;
   localparam state_t ST_DONE  = 3'd4;

   localparam int N_ANCH_DEF  = 4;
   localparam int COORD_W_DEF = 8;
   localparam int RSSI_W_DEF  = 20;
   localparam int ADDR_W_DEF  = 12;
   localparam int VAL_W_DEF   = 16;

   function automatic int sum_w_width(input int val_w, input int n_anch);
      return val_w + $clog2(n_anch);
   endfunction

   function automatic int sum_xy_width(input int val_w, input int coord_w, input int n_anch);
      return val_w + coord_w + $clog2(n_anch);
   endfunction

   localparam int SW  = sum_w_width(VAL_W_DEF, N_ANCH_DEF);
   localparam int SXY = sum_xy_width(VAL_W_DEF, COORD_W_DEF, N_ANCH_DEF);

   // Cycles from the edge accepting the last anchor to the out_valid strobe
   localparam int LAT = COORD_W_DEF + 4;

endpackage

// File: rtl/rfile_div.sv
// Restoring divider producing a Q_W-bit quotient in exactly Q_W cycles after start.
// The caller guarantees the quotient fits in Q_W bits.
module rfile_div #(
   parameter int DVD_W = 26,
   parameter int DVS_W = 18,
   parameter int Q_W   = 8
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [DVD_W-1:0] dividend,
   input  logic [DVS_W-1:0] divisor,
   output logic             done,
   output logic [Q_W-1:0]   quotient
);

   localparam int CNT_W = (Q_W > 1) ? $clog2(Q_W) : 1;

   logic [DVS_W-1:0] rem;
   logic [DVS_W-1:0] dvs;
   logic [Q_W-1:0]   dvd_lo;
   logic [CNT_W-1:0] cnt;
   logic             run;
   logic [DVS_W:0]   trial;
   logic [DVS_W:0]   diff;
   logic             ge;

   assign trial = {rem, dvd_lo[Q_W-1]};
   assign diff  = trial - {1'b0, dvs};
   assign ge    = (trial >= {1'b0, dvs});

   // Quotient fits Q_W bits, so the dividend bits above Q_W start out below
   // the divisor and only Q_W shift/subtract steps are needed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem      <= '0;
         dvs      <= '0;
         dvd_lo   <= '0;
         cnt      <= '0;
         run      <= 1'b0;
         done     <= 1'b0;
         quotient <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            rem    <= DVS_W'(dividend >> Q_W);
            dvd_lo <= dividend[Q_W-1:0];
            dvs    <= divisor;
            cnt    <= CNT_W'(Q_W - 1);
            run    <= 1'b1;
         end else if (run) begin
            rem      <= ge ? diff[DVS_W-1:0] : trial[DVS_W-1:0];
            quotient <= {quotient[Q_W-2:0], ge};
            dvd_lo   <= dvd_lo << 1;
            if (cnt == '0) begin
               run  <= 1'b0;
               done <= 1'b1;
            end else begin
               cnt <= cnt - 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/rfile_wcent.sv
// Weighted-centroid localisation: streams N_ANCH anchors, weights each RSSI
// through the shared ROM and emits the round-half-up centroid (xt, yt).
module rfile_wcent
   import rfile_pkg::*;
#(
   parameter int N_ANCH  = N_ANCH_DEF,
   parameter int COORD_W = COORD_W_DEF,
   parameter int RSSI_W  = RSSI_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int VAL_W   = VAL_W_DEF
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [COORD_W-1:0] anc_x,
   input  logic [COORD_W-1:0] anc_y,
   input  logic [RSSI_W-1:0]  rssi,
   output logic [ADDR_W-1:0]  lut_addr,
   input  logic [VAL_W-1:0]   lut_data,
   output logic               busy,
   output logic               out_valid,
   output logic [COORD_W-1:0] xt,
   output logic [COORD_W-1:0] yt,
   output logic               degen
);

   localparam int SW_L  = sum_w_width(VAL_W, N_ANCH);
   localparam int SXY_L = sum_xy_width(VAL_W, COORD_W, N_ANCH);
   localparam int CW    = $clog2(N_ANCH);

   state_t                     state;
   logic [CW-1:0]              anc_cnt;
   logic                       drain_cnt;
   logic                       acc_v;
   logic [COORD_W-1:0]         x_d;
   logic [COORD_W-1:0]         y_d;
   logic [SW_L-1:0]            sum_w;
   logic [SXY_L-1:0]           sum_wx;
   logic [SXY_L-1:0]           sum_wy;
   logic [VAL_W+COORD_W-1:0]   prod_x;
   logic [VAL_W+COORD_W-1:0]   prod_y;
   logic [SXY_L-1:0]           dvd_x;
   logic [SXY_L-1:0]           dvd_y;
   logic                       div_start;
   logic                       div_x_done;
   logic                       div_y_done;
   logic [COORD_W-1:0]         qx;
   logic [COORD_W-1:0]         qy;
   logic                       accept;
   logic                       last_acc;
   logic                       all_zero;

   assign busy      = (state == ST_DRAIN) || (state == ST_DIV) || (state == ST_DONE);
   assign out_valid = (state == ST_DONE);
   assign accept    = in_valid && !busy;
   assign last_acc  = accept && (anc_cnt == CW'(N_ANCH - 1));
   assign prod_x    = lut_data * x_d;
   assign prod_y    = lut_data * y_d;
   assign dvd_x     = sum_wx + SXY_L'(sum_w >> 1);
   assign dvd_y     = sum_wy + SXY_L'(sum_w >> 1);
   assign all_zero  = (sum_w == '0);

   generate
      if (RSSI_W > ADDR_W) begin : g_rssi_lsb
         logic unused_rssi_lsb;
         assign unused_rssi_lsb = ^rssi[RSSI_W-ADDR_W-1:0];
      end
   endgenerate

   // DRAIN waits for the last weight to land; div_start is registered so the
   // dividers load one edge after DIV entry, which fixes the total latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         anc_cnt   <= '0;
         drain_cnt <= 1'b0;
         div_start <= 1'b0;
      end else begin
         div_start <= 1'b0;
         if (accept) anc_cnt <= last_acc ? '0 : anc_cnt + 1'b1;
         case (state)
            ST_IDLE:  if (accept) state <= ST_ACC;
            ST_ACC:   if (last_acc) state <= ST_DRAIN;
            ST_DRAIN: begin
               drain_cnt <= ~drain_cnt;
               if (drain_cnt) begin
                  state     <= ST_DIV;
                  div_start <= 1'b1;
               end
            end
            ST_DIV:   if (div_x_done && div_y_done) state <= ST_DONE;
            ST_DONE:  state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lut_addr <= '0;
         x_d      <= '0;
         y_d      <= '0;
         acc_v    <= 1'b0;
         sum_w    <= '0;
         sum_wx   <= '0;
         sum_wy   <= '0;
      end else begin
         acc_v <= accept;
         if (accept) begin
            lut_addr <= rssi[RSSI_W-1 -: ADDR_W];
            x_d      <= anc_x;
            y_d      <= anc_y;
         end
         if (state == ST_DONE) begin
            sum_w  <= '0;
            sum_wx <= '0;
            sum_wy <= '0;
         end else if (acc_v) begin
            sum_w  <= sum_w + SW_L'(lut_data);
            sum_wx <= sum_wx + SXY_L'(prod_x);
            sum_wy <= sum_wy + SXY_L'(prod_y);
         end
      end
   end

   // Dividers always run so a zero-weight frame keeps the same latency;
   // their quotient is simply discarded in that case.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xt    <= '0;
         yt    <= '0;
         degen <= 1'b0;
      end else if ((state == ST_DIV) && div_x_done && div_y_done) begin
         xt    <= all_zero ? '0 : qx;
         yt    <= all_zero ? '0 : qy;
         degen <= all_zero;
      end
   end

   rfile_div #(.DVD_W(SXY_L), .DVS_W(SW_L), .Q_W(COORD_W)) u_div_x (
      .clk      (clk),
      .rst      (rst),
      .start    (div_start),
      .dividend (dvd_x),
      .divisor  (sum_w),
      .done     (div_x_done),
      .quotient (qx)
   );

   rfile_div #(.DVD_W(SXY_L), .DVS_W(SW_L), .Q_W(COORD_W)) u_div_y (
      .clk      (clk),
      .rst      (rst),
      .start    (div_start),
      .dividend (dvd_y),
      .divisor  (sum_w),
      .done     (div_y_done),
      .quotient (qy)
   );

endmodule

// File: tb/tb_rfile_wcent.sv
// Self-checking bench for rfile_wcent: directed frames plus random frames
// compared against an arithmetic centroid model and a behavioural weight ROM.
module tb_rfile_wcent;
   import rfile_pkg::*;

   localparam int NA = 4;
   localparam int CWID = 8;
   localparam int RW = 20;
   localparam int AW = 12;
   localparam int VW = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic [CWID-1:0] anc_x;
   logic [CWID-1:0] anc_y;
   logic [RW-1:0]   rssi;
   logic [AW-1:0]   lut_addr;
   logic [VW-1:0]   lut_data;
   logic            busy;
   logic            out_valid;
   logic [CWID-1:0] xt;
   logic [CWID-1:0] yt;
   logic            degen;

   logic [VW-1:0] rom [0:4095];
   int cyc = 0;
   int nVectors = 0;
   int nErrors = 0;
   int fx[NA];
   int fy[NA];
   int fw[NA];
   longint expX, expY, expDegen;

   rfile_wcent dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .anc_x     (anc_x),
      .anc_y     (anc_y),
      .rssi      (rssi),
      .lut_addr  (lut_addr),
      .lut_data  (lut_data),
      .busy      (busy),
      .out_valid (out_valid),
      .xt        (xt),
      .yt        (yt),
      .degen     (degen)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign lut_data = rom[lut_addr];

   task automatic checkOutput(input string tag, input longint obs, input longint exp);
      nVectors++;
      if (obs !== exp) begin
         nErrors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic setAnchor(input int k, input int x, input int y, input int w);
      fx[k] = x;
      fy[k] = y;
      fw[k] = w;
   endtask

   // Reference centroid: round-half-up of sum(w*c)/sum(w), zero when no weight
   task automatic computeExpected();
      longint sw, sx, sy;
      sw = 0; sx = 0; sy = 0;
      for (int k = 0; k < NA; k++) begin
         sw += fw[k];
         sx += longint'(fw[k]) * fx[k];
         sy += longint'(fw[k]) * fy[k];
      end
      if (sw == 0) begin
         expX = 0; expY = 0; expDegen = 1;
      end else begin
         expX = (sx + sw / 2) / sw;
         expY = (sy + sw / 2) / sw;
         expDegen = 0;
      end
   endtask

   // Entered and left on a falling edge; streams one frame and checks the result
   task automatic applyStimulus(input bit gaps, input bit holdValid);
      int base, lastAcc;
      bit seen;
      computeExpected();
      base = $urandom_range(0, 1023) * 4;
      for (int k = 0; k < NA; k++) rom[base + k] = VW'(fw[k]);
      lastAcc = 0;
      for (int k = 0; k < NA; k++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               in_valid = 1'b0;
               @(negedge clk);
            end
         end
         in_valid = 1'b1;
         anc_x = CWID'(fx[k]);
         anc_y = CWID'(fy[k]);
         rssi = {AW'(base + k), 8'($urandom)};
         checkOutput("busy_at_accept", busy, 0);
         @(posedge clk);
         #1;
         checkOutput("lut_addr", lut_addr, base + k);
         if (k == NA - 1) lastAcc = cyc;
         @(negedge clk);
      end
      if (holdValid) begin
         in_valid = 1'b1;
         anc_x = CWID'($urandom);
         anc_y = CWID'($urandom);
         rssi = RW'($urandom);
      end else begin
         in_valid = 1'b0;
      end
      checkOutput("busy_after_last", busy, 1);
      seen = 1'b0;
      for (int i = 0; i < LAT + 10 && !seen; i++) begin
         if (out_valid) seen = 1'b1;
         else @(negedge clk);
      end
      if (!seen) begin
         checkOutput("out_valid_timeout", 0, 1);
      end else begin
         checkOutput("latency", cyc - lastAcc, LAT);
         checkOutput("xt", xt, expX);
         checkOutput("yt", yt, expY);
         checkOutput("degen", degen, expDegen);
         checkOutput("busy_in_done", busy, 1);
      end
      @(negedge clk);
      checkOutput("out_valid_pulse", out_valid, 0);
      checkOutput("busy_release", busy, 0);
      checkOutput("xt_hold", xt, expX);
      checkOutput("degen_hold", degen, expDegen);
      if (holdValid) checkOutput("lut_addr_ignored", lut_addr, base + NA - 1);
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      anc_x = '0;
      anc_y = '0;
      rssi = '0;
      for (int a = 0; a < 4096; a++) rom[a] = '0;
      repeat (3) @(negedge clk);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_xt", xt, 0);
      checkOutput("rst_yt", yt, 0);
      checkOutput("rst_degen", degen, 0);
      checkOutput("rst_lut_addr", lut_addr, 0);
      rst = 1'b0;
      @(negedge clk);

      setAnchor(0, 10, 10, 1); setAnchor(1, 30, 10, 1);
      setAnchor(2, 10, 30, 1); setAnchor(3, 30, 30, 1);
      applyStimulus(1'b0, 1'b0);

      setAnchor(0, 0, 0, 1);   setAnchor(1, 100, 0, 1);
      setAnchor(2, 0, 100, 2); setAnchor(3, 50, 50, 0);
      applyStimulus(1'b0, 1'b0);

      setAnchor(0, 0, 5, 1); setAnchor(1, 0, 5, 1);
      setAnchor(2, 1, 5, 1); setAnchor(3, 9, 5, 0);
      applyStimulus(1'b0, 1'b0);

      setAnchor(0, 0, 7, 1); setAnchor(1, 1, 8, 1);
      setAnchor(2, 1, 8, 1); setAnchor(3, 9, 9, 0);
      applyStimulus(1'b1, 1'b0);

      setAnchor(0, 40, 90, 0); setAnchor(1, 200, 3, 0);
      setAnchor(2, 17, 250, 0); setAnchor(3, 99, 1, 0);
      applyStimulus(1'b0, 1'b0);

      for (int k = 0; k < NA; k++) setAnchor(k, 255, 255, 65535);
      applyStimulus(1'b0, 1'b0);

      // Reset after two accepts must drop the partial frame and clear outputs
      for (int k = 0; k < 2; k++) begin
         in_valid = 1'b1;
         anc_x = 8'd77;
         anc_y = 8'd66;
         rssi = RW'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      checkOutput("midrst_xt", xt, 0);
      checkOutput("midrst_yt", yt, 0);
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_lut_addr", lut_addr, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      setAnchor(0, 10, 10, 1); setAnchor(1, 30, 10, 1);
      setAnchor(2, 10, 30, 1); setAnchor(3, 30, 30, 1);
      applyStimulus(1'b0, 1'b0);

      setAnchor(0, 5, 60, 3);  setAnchor(1, 120, 61, 9);
      setAnchor(2, 33, 200, 1); setAnchor(3, 250, 14, 4);
      applyStimulus(1'b0, 1'b1);
      setAnchor(0, 1, 2, 7);  setAnchor(1, 3, 4, 7);
      setAnchor(2, 5, 6, 7);  setAnchor(3, 7, 8, 7);
      applyStimulus(1'b0, 1'b0);

      for (int f = 0; f < 25; f++) begin
         for (int k = 0; k < NA; k++) begin
            int w;
            w = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 65535));
            if (f % 8 == 7) w = 0;
            setAnchor(k, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), w);
         end
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      in_valid = 1'b0;
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nErrors);
      $finish;
   end

endmodule
